// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a 2-entry skid buffer, valid/ready handshake,
// stage flush and a saturating downstream stall counter.
module pipe_stage_elastic #(
  parameter int DATA_W             = 48,
  parameter int CTRL_W             = 16,
  parameter bit ZERO_DATA_ON_FLUSH = 1'b1,
  parameter int STALL_CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t                 main_q, main_n;
  entry_t                 skid_q, skid_n;
  entry_t                 in_entry;
  logic                   in_ready_q, in_ready_n;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_n;

  logic up_xfer, dn_xfer, main_free;

  assign up_xfer   = in_valid & in_ready_q;
  assign dn_xfer   = main_q.valid & out_ready;
  assign main_free = ~main_q.valid | dn_xfer;

  always_comb begin
    in_entry.valid = 1'b1;
    in_entry.ctrl  = in_ctrl;
    in_entry.data  = in_data;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    main_n = main_q;
    skid_n = skid_q;
    if (flush) begin
      // Downstream already sampled main if it was draining; the input is dropped.
      main_n.valid = 1'b0;
      main_n.ctrl  = '0;
      skid_n.valid = 1'b0;
      skid_n.ctrl  = '0;
      if (ZERO_DATA_ON_FLUSH) begin
        main_n.data = '0;
        skid_n.data = '0;
      end
    end else if (main_free) begin
      if (skid_q.valid) begin
        main_n = skid_q;
        if (up_xfer) skid_n = in_entry;
        else         skid_n.valid = 1'b0;
      end else if (up_xfer) begin
        main_n = in_entry;
      end else begin
        main_n.valid = 1'b0;
      end
    end else if (up_xfer) begin
      skid_n = in_entry;
    end
    in_ready_n = ~skid_n.valid;
  end

  always_comb begin
    stall_cnt_n = stall_cnt_q;
    if (main_q.valid && !out_ready && !flush && !(&stall_cnt_q))
      stall_cnt_n = stall_cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two entries are plain flops, so clearing their payload on
      // reset is cheap and keeps out_data deterministic after reset.
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      main_q      <= main_n;
      skid_q      <= skid_n;
      in_ready_q  <= in_ready_n;
      stall_cnt_q <= stall_cnt_n;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_q.valid;
  assign out_ctrl  = main_q.valid ? main_q.ctrl : '0;
  assign out_data  = main_q.data;
  assign occupancy = {1'b0, main_q.valid} + {1'b0, skid_q.valid};
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: two instances (zeroing flush, wide
// counter / retaining flush, 3-bit counter) share one stimulus stream.
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_ctrl = '0;
  logic [47:0] in_data = '0;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [15:0] a_out_ctrl, b_out_ctrl;
  logic [47:0] a_out_data, b_out_data;
  logic [1:0]  a_occ, b_occ;
  logic [15:0] a_stall;
  logic [2:0]  b_stall;

  always #5 clk = ~clk;

  pipe_stage_elastic dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .occupancy(a_occ), .stall_cnt(a_stall)
  );

  pipe_stage_elastic #(.ZERO_DATA_ON_FLUSH(1'b0), .STALL_CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occ), .stall_cnt(b_stall)
  );

  typedef struct {
    logic [15:0] ctrl;
    logic [47:0] data;
  } item_t;

  item_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_stall_a = 0;
  int    exp_stall_b = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [47:0] mk_data(input logic [15:0] c);
    return {16'hDA7A, ~c, c};
  endfunction

  // Compare registered outputs against the scoreboard occupancy and stall model.
  task automatic check_state();
    int sz = q.size();
    check("a_occ",       64'(a_occ),       64'(sz));
    check("b_occ",       64'(b_occ),       64'(sz));
    check("a_in_ready",  64'(a_in_ready),  64'(sz < 2));
    check("b_in_ready",  64'(b_in_ready),  64'(sz < 2));
    check("a_out_valid", 64'(a_out_valid), 64'(sz > 0));
    check("b_out_valid", 64'(b_out_valid), 64'(sz > 0));
    check("a_stall",     64'(a_stall),     64'(exp_stall_a));
    check("b_stall",     64'(b_stall),     64'(exp_stall_b));
    if (sz == 0) begin
      check("a_ctrl_gated", 64'(a_out_ctrl), 64'h0);
      check("b_ctrl_gated", 64'(b_out_ctrl), 64'h0);
    end
  endtask

  // Called at a negedge: drive inputs, settle the model for the coming edge.
  task automatic step(input logic v, input logic [15:0] c, input logic ordy, input logic fl);
    item_t it;
    int    sz;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = mk_data(c);
    out_ready = ordy;
    flush     = fl;
    sz = q.size();
    if (rst) begin
      q.delete();
      exp_stall_a = 0;
      exp_stall_b = 0;
    end else begin
      if (sz > 0 && ordy) begin
        it = q.pop_front();
        check("a_out_ctrl", 64'(a_out_ctrl), 64'(it.ctrl));
        check("a_out_data", 64'(a_out_data), 64'(it.data));
        check("b_out_ctrl", 64'(b_out_ctrl), 64'(it.ctrl));
      end
      if (sz > 0 && !ordy && !fl) begin
        if (exp_stall_a < 65535) exp_stall_a++;
        if (exp_stall_b < 7)     exp_stall_b++;
      end
      if (fl) q.delete();
      else if (v && sz < 2) begin
        it.ctrl = c;
        it.data = mk_data(c);
        q.push_back(it);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  logic [47:0] saved_data;

  initial begin
    // Reset
    @(negedge clk);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0BAD, 1'b1, 1'b1);
    check("a_rst_data", 64'(a_out_data), 64'h0);
    rst = 1'b0;

    // Streaming, one per cycle
    for (int i = 1; i <= 5; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // Backpressure: A3 held off while both entries are full
    step(1'b1, 16'h00A1, 1'b0, 1'b0);
    step(1'b1, 16'h00A2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h00A3, 1'b0, 1'b0);
    step(1'b1, 16'h00A3, 1'b1, 1'b0);
    step(1'b1, 16'h00A3, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // Flush with a full buffer and a coincident offer of 0x00FF
    step(1'b1, 16'h00B1, 1'b0, 1'b0);
    step(1'b1, 16'h00B2, 1'b0, 1'b0);
    saved_data = mk_data(16'h00B1);
    step(1'b1, 16'h00FF, 1'b0, 1'b1);
    check("a_flush_data_zero", 64'(a_out_data), 64'h0);
    check("b_flush_data_kept", 64'(b_out_data), 64'(saved_data));
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // Flush coinciding with a downstream transfer
    step(1'b1, 16'h00C1, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // Reset priority over flush with a full buffer; no edge means no effect
    step(1'b1, 16'h00D1, 1'b0, 1'b0);
    step(1'b1, 16'h00D2, 1'b0, 1'b0);
    rst   = 1'b1;
    flush = 1'b1;
    #2;
    check("rst_no_edge_occ",   64'(a_occ),       64'd2);
    check("rst_no_edge_valid", 64'(a_out_valid), 64'd1);
    step(1'b1, 16'h00D3, 1'b1, 1'b1);
    check("a_rst2_data", 64'(a_out_data), 64'h0);
    check("b_rst2_data", 64'(b_out_data), 64'h0);
    rst = 1'b0;

    // Stall counter saturation (3-bit instance saturates at 7)
    step(1'b1, 16'h00E1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
    check("b_stall_sat", 64'(b_stall), 64'd7);
    check("a_stall_10",  64'(a_stall), 64'd10);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
